mul_unit: RTL and testbench
===========================

// Module: mul_unit
// PURPOSE
//  Iterative RV64M multiplier executing MUL/MULH/MULHSU/MULHU/MULW for the core's execute stage.
//  - Accepts one operation per request over a valid/ready handshake.
//  - Returns the 64-bit rd value over a second valid/ready handshake.
//  - Sits beside the ALU; the execute stage stalls the pipeline until the response is consumed.
// PARAMETERS
//  XLEN            64  operand/result width (only 64 supported)
//  BITS_PER_CYCLE   4  multiplier bits retired per CALC cycle; must divide XLEN (1,2,4,8)
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst_n       in   1     asynchronous active-low reset
//  flush       in   1     abort any in-flight op (pipeline redirect)
//  req_valid   in   1     request present
//  req_ready   out  1     unit can accept request
//  req_funct3  in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; others treated as MUL
//  req_word    in   1     1 = MULW (low 32 bits of each operand, funct3 must be 000)
//  req_a       in   XLEN  rs1 value
//  req_b       in   XLEN  rs2 value
//  resp_valid  out  1     result present
//  resp_ready  in   1     consumer accepts result
//  resp_data   out  XLEN  rd value
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, accumulators=0.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: req_ready=1. On req_valid, latch operands/op, go to CALC.
//    - Signedness: a signed for MULH/MULHSU; b signed for MULH only.
//    - MUL: sign irrelevant, treated unsigned.
//    - MULW: a[31:0], b[31:0] zero-extended.
//    - Store operand magnitudes plus neg = sign(a)^sign(b) for signed ops.
//  - CALC: each cycle add (|a| << k)*(next BITS_PER_CYCLE bits of |b|) into a 2*XLEN accumulator.
//    - After XLEN/BITS_PER_CYCLE cycles, go to DONE. No early termination on zero operands.
//  - DONE: resp_valid=1, resp_data held stable until resp_ready=1, then IDLE.
//    - Product P = neg ? -acc : acc (2*XLEN two's complement).
//    - MUL -> P[63:0]. MULH/MULHSU/MULHU -> P[127:64].
//    - MULW -> sign-extend P[31:0] to 64 bits.
//    - resp_data is registered on the CALC->DONE transition.
//  - Latency: request accepted in cycle 0 -> resp_valid in cycle XLEN/BITS_PER_CYCLE+1 (17 at defaults).
//  - req_ready=0 in CALC and DONE; no back-to-back overlap.
//    - Next req may be accepted the cycle after the resp handshake.
//  - flush=1 in any state: next state IDLE, resp_valid=0, any req that cycle ignored; flush wins over handshakes.
//  - resp_ready held 0 in DONE: stay in DONE indefinitely, data unchanged.
//  - Overflow never flagged; results wrap per RISC-V spec (e.g. MULH(min,min) = 0x4000000000000000).
//  - Reset mid-CALC/DONE: immediately back to reset values; partial result discarded.
// TESTING
//  Operands: A=FF22334455667788, B=00000000AABB0077, C=0000000087654321. Results:
//  - MUL A,B -> 6C8641FD52F99038; MULH A,B -> FFFFFFFFFF6C1406.
//  - MULHU A,B -> 00000000AA27147D; MULHSU A,B -> FFFFFFFFFF6C1406; MULHSU B,A -> 00000000AA27147D.
//  - MULW A,B -> 0000000052F99038; MULW A,C -> FFFFFFFFB4260088; MULH A,A -> 0000C02B1FC02E8C.
//  - Timing: resp_valid exactly 17 cycles after accept; hold resp_ready=0 for 5 cycles -> data stable, req_ready=0.
//  - Corners: MULH 8000000000000000,8000000000000000 -> 4000000000000000; MUL x,0 -> 0 after full latency.
//  - Abort: flush in CALC cycle 5 -> IDLE next cycle, no resp_valid; fresh MUL 3,5 -> 000000000000000F.
//    rst_n low mid-CALC -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_unit
// Brief   : Iterative RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Revision: 1.0
// ============================================================================
module mul_unit #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int DW    = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DW-1:0]     r_a_sh;
  logic [XLEN-1:0]   r_b_sh;
  logic [DW-1:0]     r_acc;
  logic              r_neg;
  logic              r_hi_sel;
  logic              r_word_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_resp_data;

  logic              w_accept;
  logic              w_last;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_op_a;
  logic [XLEN-1:0]   w_op_b;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_hi;
  logic [DW-1:0]     w_partial;
  logic [DW-1:0]     w_acc_sum;
  logic [DW-1:0]     w_prod;
  logic [XLEN-1:0]   w_result;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign resp_data  = r_resp_data;
  assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
  assign w_last     = (r_cnt == LAST_STEP);

  // MULW forces an unsigned low-word multiply regardless of funct3.
  assign w_a_signed = !req_word && ((req_funct3 == 3'b001) || (req_funct3 == 3'b010));
  assign w_b_signed = !req_word && (req_funct3 == 3'b001);
  assign w_hi       = !req_word && ((req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                                    (req_funct3 == 3'b011));
  assign w_op_a     = req_word ? {{(XLEN-32){1'b0}}, req_a[31:0]} : req_a;
  assign w_op_b     = req_word ? {{(XLEN-32){1'b0}}, req_b[31:0]} : req_b;
  assign w_a_neg    = w_a_signed && w_op_a[XLEN-1];
  assign w_b_neg    = w_b_signed && w_op_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? -w_op_a : w_op_a;
  assign w_mag_b    = w_b_neg ? -w_op_b : w_op_b;

  // One radix-2^BITS_PER_CYCLE digit of |b| times the pre-shifted |a|.
  always_comb begin
    w_partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_b_sh[i]) begin
        w_partial = w_partial + (r_a_sh << i);
      end
    end
  end

  assign w_acc_sum = r_acc + w_partial;
  assign w_prod    = r_neg ? -w_acc_sum : w_acc_sum;

  always_comb begin
    w_result = w_prod[XLEN-1:0];
    if (r_word_sel) begin
      w_result = {{(XLEN-32){w_prod[31]}}, w_prod[31:0]};
    end else if (r_hi_sel) begin
      w_result = w_prod[DW-1:XLEN];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_next = S_CALC;
      S_CALC: if (w_last)    w_state_next = S_DONE;
      S_DONE: if (resp_ready) w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
    if (flush) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_acc       <= '0;
      r_neg       <= 1'b0;
      r_hi_sel    <= 1'b0;
      r_word_sel  <= 1'b0;
      r_cnt       <= '0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a_sh     <= {{XLEN{1'b0}}, w_mag_a};
        r_b_sh     <= w_mag_b;
        r_acc      <= '0;
        r_neg      <= w_a_neg ^ w_b_neg;
        r_hi_sel   <= w_hi;
        r_word_sel <= req_word;
        r_cnt      <= '0;
      end else if ((r_state == S_CALC) && !flush) begin
        r_acc  <= w_acc_sum;
        r_a_sh <= r_a_sh << BITS_PER_CYCLE;
        r_b_sh <= r_b_sh >> BITS_PER_CYCLE;
        r_cnt  <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_resp_data <= w_result;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// Self-checking bench for mul_unit: scoreboard of expected rd values,
// one task per scenario.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b000;
  logic        req_word = 1'b0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_data;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] OP_A = 64'hFF22334455667788;
  localparam logic [63:0] OP_B = 64'h00000000AABB0077;
  localparam logic [63:0] OP_C = 64'h0000000087654321;

  mul_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_word   (req_word),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1, "watchdog");
  end

  // Reference product built from full-width arithmetic on extended operands.
  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    if (w) begin
      ea = {96'b0, a[31:0]};
      eb = {96'b0, b[31:0]};
      p  = ea * eb;
      return {{32{p[31]}}, p[31:0]};
    end
    ea = ((f3 == 3'b001) || (f3 == 3'b010)) ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (f3 == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    if ((f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011)) return p[127:64];
    return p[63:0];
  endfunction

  // Enter just after a posedge or at a negedge; returns #1 after the accept edge.
  task automatic send(input logic [2:0] f3, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp_val);
    int n;
    n = 0;
    req_funct3 = f3;
    req_word   = w;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    exp_q.push_back(exp_val);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for resp_valid, compares against the scoreboard, completes handshake.
  task automatic recv(input string name, output int lat);
    int n;
    logic [63:0] e;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    lat = n;
    tests++;
    if (resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: resp_valid=%b required 1", name, resp_valid);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
    tests++;
    if (resp_data !== e) begin
      fails++;
      $display("FAIL %s: resp_data=%h required %h", name, resp_data, e);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h required 1 0 0",
               req_ready, resp_valid, resp_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops();
    int lat;
    send(3'b000, 1'b0, OP_A, OP_B, 64'h6C8641FD52F99038); recv("mul_ab", lat);
    send(3'b001, 1'b0, OP_A, OP_B, 64'hFFFFFFFFFF6C1406); recv("mulh_ab", lat);
    send(3'b011, 1'b0, OP_A, OP_B, 64'h00000000AA27147D); recv("mulhu_ab", lat);
    send(3'b010, 1'b0, OP_A, OP_B, 64'hFFFFFFFFFF6C1406); recv("mulhsu_ab", lat);
    send(3'b010, 1'b0, OP_B, OP_A, 64'h00000000AA27147D); recv("mulhsu_ba", lat);
    send(3'b000, 1'b1, OP_A, OP_B, 64'h0000000052F99038); recv("mulw_ab", lat);
    send(3'b000, 1'b1, OP_A, OP_C, 64'hFFFFFFFFB4260088); recv("mulw_ac", lat);
    send(3'b001, 1'b0, OP_A, OP_A, 64'h0000C02B1FC02E8C); recv("mulh_aa", lat);
    send(3'b111, 1'b0, OP_A, OP_B, 64'h6C8641FD52F99038); recv("f3_other_as_mul", lat);
  endtask

  task automatic test_timing();
    int n;
    logic [63:0] e;
    send(3'b000, 1'b0, OP_A, OP_B, 64'h6C8641FD52F99038);
    resp_ready = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    tests++;
    if (n != 17) begin
      fails++;
      $display("FAIL latency: got %0d cycles required 17", n);
    end
    e = exp_q.pop_front();
    // A competing request during the stall must be ignored.
    req_valid = 1'b1;
    req_a     = 64'd9;
    req_b     = 64'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (resp_valid !== 1'b1 || resp_data !== e || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold: vld=%b data=%h rdy=%b required 1 %h 0",
                 resp_valid, resp_data, req_ready, e);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL after_handshake: vld=%b rdy=%b required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_corners();
    int lat;
    send(3'b001, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000);
    recv("mulh_min_min", lat);
    send(3'b000, 1'b0, 64'h123456789ABCDEF0, 64'h0, 64'h0);
    recv("mul_x_zero", lat);
    tests++;
    if (lat != 17) begin
      fails++;
      $display("FAIL zero_latency: got %0d cycles required 17", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] a, b;
    logic [2:0]  f3;
    logic        w;
    for (int i = 0; i < 10; i++) begin
      a  = (i == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
      b  = (i == 1) ? 64'h8000000000000000 : {$urandom, $urandom};
      w  = ($urandom_range(0, 3) == 0);
      f3 = w ? 3'b000 : 3'($urandom_range(0, 3));
      send(f3, w, a, b, model(f3, w, a, b));
      recv("random_op", lat);
      tests++;
      if (req_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready: req_ready=%b required 1", req_ready);
      end
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    // Flush beats a request presented in the same IDLE cycle.
    req_valid = 1'b1;
    flush     = 1'b1;
    req_a     = 64'd7;
    req_b     = 64'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_idle_req: req_ready=%b required 1", req_ready);
    end
    send(3'b000, 1'b0, OP_A, OP_B, 64'h0);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_calc: rdy=%b vld=%b required 1 0", req_ready, resp_valid);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL flush_no_resp: resp_valid cycles=%0d required 0", seen);
    end
    send(3'b000, 1'b0, 64'd3, 64'd5, 64'h000000000000000F);
    recv("mul_3_5_after_flush", lat);
  endtask

  task automatic test_async_reset();
    send(3'b000, 1'b0, OP_A, OP_B, 64'h0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'h0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b vld=%b data=%h required 1 0 0",
               req_ready, resp_valid, resp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: rdy=%b vld=%b required 1 0", req_ready, resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_timing();
    test_corners();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
